flt_flt: RTL and testbench

- Self-contained half-precision (1/5/10) floating-point adder with an internal byte-wide data memory.
- On request it reads two operands from memory, adds them with a multi-cycle FSM, writes the 16-bit sum back to memory, and raises done.
- It is the "program 3" float-add engine. The surrounding bench accesses the memory hierarchically as instance data_mem1, array my_memory.

---
 rtl/flt_flt.sv | 237 +++++++++++++++++++++++
 tb/tb_flt_flt.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/flt_flt.sv
// Half-precision (1/5/10) float adder with a private byte memory: reads two operands, adds them, writes the sum back.
// Optional round-to-nearest-even build: define FLT_ROUND_NEAREST_EN (default build truncates toward zero).

module flt_flt_mem #(
  parameter int MEM_DEPTH = 256,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);
  logic [7:0] my_memory [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) my_memory[i_addr] <= i_wdata;
  end

  assign o_rdata = my_memory[i_addr];
endmodule

module flt_flt #(
  parameter int MEM_DEPTH = 256,
  parameter int OP_BASE   = 128
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic done
);
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [AW-1:0] A_OP1H = AW'(OP_BASE);
  localparam logic [AW-1:0] A_OP1L = AW'(OP_BASE + 1);
  localparam logic [AW-1:0] A_OP2H = AW'(OP_BASE + 2);
  localparam logic [AW-1:0] A_OP2L = AW'(OP_BASE + 3);
  localparam logic [AW-1:0] A_RESH = AW'(OP_BASE + 4);
  localparam logic [AW-1:0] A_RESL = AW'(OP_BASE + 5);

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_UNPACK, S_ALIGN, S_ADDSUB, S_NORM,
`ifdef FLT_ROUND_NEAREST_EN
    S_ROUND,
`endif
    S_PACK, S_WR_HI, S_WR_LO, S_DONE
  } state_t;

`ifdef FLT_ROUND_NEAREST_EN
  localparam state_t S_POST_NORM = S_ROUND;
`else
  localparam state_t S_POST_NORM = S_PACK;
`endif

  state_t r_state, w_state_nxt;

  logic          r_armed;
  logic [15:0]   r_op1, r_op2;
  logic          r_sa, r_sb;
  logic [6:0]    r_exp;      // two's complement working exponent of A / result
  logic [4:0]    r_eb;
  logic [13:0]   r_ma, r_mb; // {hidden, 10 fraction, guard, round, sticky}
  logic [3:0]    r_cnt;
  logic [14:0]   r_sum;
  logic          r_sign, r_zero;
  logic [15:0]   r_res;

  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_wdata, w_rdata;

  flt_flt_mem #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) data_mem1 (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // Operands with a zero exponent become true zeros so they lose every magnitude compare.
  logic [4:0]  w_e1, w_e2;
  logic [10:0] w_m1, w_m2;
  logic        w_swap;
  assign w_e1   = r_op1[14:10];
  assign w_e2   = r_op2[14:10];
  assign w_m1   = (w_e1 == 5'd0) ? 11'd0 : {1'b1, r_op1[9:0]};
  assign w_m2   = (w_e2 == 5'd0) ? 11'd0 : {1'b1, r_op2[9:0]};
  assign w_swap = {w_e2, w_m2} > {w_e1, w_m1};

  logic        w_aligned;
  logic [14:0] w_sum;
  logic        w_sum_zero;
  assign w_aligned  = (r_exp[4:0] == r_eb) || (r_cnt == 4'd13);
  assign w_sum      = (r_sa == r_sb) ? ({1'b0, r_ma} + {1'b0, r_mb})
                                     : ({1'b0, r_ma} - {1'b0, r_mb});
  assign w_sum_zero = (w_sum == 15'd0);

  logic w_under, w_over;
  assign w_under = r_exp[6] || (r_exp == 7'd0);
  assign w_over  = !r_exp[6] && r_exp[5];

`ifdef FLT_ROUND_NEAREST_EN
  logic        w_inc;
  logic [11:0] w_rnd;
  assign w_inc = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
  assign w_rnd = {1'b0, r_sum[13:3]} + {11'd0, w_inc};
`endif

  assign done = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!req && r_armed) w_state_nxt = S_RD0;
      S_RD0:    w_state_nxt = S_RD1;
      S_RD1:    w_state_nxt = S_RD2;
      S_RD2:    w_state_nxt = S_RD3;
      S_RD3:    w_state_nxt = S_UNPACK;
      S_UNPACK: w_state_nxt = S_ALIGN;
      S_ALIGN:  if (w_aligned) w_state_nxt = S_ADDSUB;
      S_ADDSUB: w_state_nxt = w_sum_zero ? S_PACK : S_NORM;
      S_NORM:   if (r_sum[14] || r_sum[13]) w_state_nxt = S_POST_NORM;
`ifdef FLT_ROUND_NEAREST_EN
      S_ROUND:  w_state_nxt = S_PACK;
`endif
      S_PACK:   w_state_nxt = S_WR_HI;
      S_WR_HI:  w_state_nxt = S_WR_LO;
      S_WR_LO:  w_state_nxt = S_DONE;
      S_DONE:   if (req) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_we    = 1'b0;
    w_addr  = A_OP1H;
    w_wdata = '0;
    case (r_state)
      S_RD1:   w_addr = A_OP1L;
      S_RD2:   w_addr = A_OP2H;
      S_RD3:   w_addr = A_OP2L;
      S_WR_HI: begin w_we = 1'b1; w_addr = A_RESH; w_wdata = r_res[15:8]; end
      S_WR_LO: begin w_we = 1'b1; w_addr = A_RESL; w_wdata = r_res[7:0];  end
      default: w_addr = A_OP1H;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_armed <= 1'b0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_exp   <= '0;
      r_eb    <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_sign  <= 1'b0;
      r_zero  <= 1'b0;
      r_res   <= '0;
    end else begin
      // A run needs req seen high first, so a req held low across reset cannot restart one.
      if ((r_state == S_IDLE || r_state == S_DONE) && req) r_armed <= 1'b1;
      else if (r_state == S_IDLE && !req && r_armed)      r_armed <= 1'b0;

      case (r_state)
        S_RD0: r_op1[15:8] <= w_rdata;
        S_RD1: r_op1[7:0]  <= w_rdata;
        S_RD2: r_op2[15:8] <= w_rdata;
        S_RD3: r_op2[7:0]  <= w_rdata;
        S_UNPACK: begin
          r_cnt <= '0;
          if (w_swap) begin
            r_sa  <= r_op2[15];
            r_sb  <= r_op1[15];
            r_exp <= {2'b00, w_e2};
            r_eb  <= w_e1;
            r_ma  <= {w_m2, 3'b000};
            r_mb  <= {w_m1, 3'b000};
          end else begin
            r_sa  <= r_op1[15];
            r_sb  <= r_op2[15];
            r_exp <= {2'b00, w_e1};
            r_eb  <= w_e2;
            r_ma  <= {w_m1, 3'b000};
            r_mb  <= {w_m2, 3'b000};
          end
        end
        S_ALIGN: begin
          if (!w_aligned) begin
            r_mb  <= {1'b0, r_mb[13:2], r_mb[1] | r_mb[0]};
            r_eb  <= r_eb + 5'd1;
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_ADDSUB: begin
          r_sum  <= w_sum;
          r_sign <= r_sa;
          r_zero <= w_sum_zero;
        end
        S_NORM: begin
          if (r_sum[14]) begin
            r_sum <= {1'b0, r_sum[14:2], r_sum[1] | r_sum[0]};
            r_exp <= r_exp + 7'd1;
          end else if (!r_sum[13]) begin
            r_sum <= {r_sum[13:0], 1'b0};
            r_exp <= r_exp - 7'd1;
          end
        end
`ifdef FLT_ROUND_NEAREST_EN
        S_ROUND: begin
          if (w_rnd[11]) begin
            r_sum <= {1'b0, w_rnd[11:1], 3'b000};
            r_exp <= r_exp + 7'd1;
          end else begin
            r_sum <= {1'b0, w_rnd[10:0], 3'b000};
          end
        end
`endif
        S_PACK: begin
          if (r_zero)       r_res <= 16'h0000;
          else if (w_under) r_res <= {r_sign, 15'd0};
          else if (w_over)  r_res <= {r_sign, 5'h1F, 10'h3FF};
          else              r_res <= {r_sign, r_exp[4:0], r_sum[12:3]};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_flt_flt.sv
// Self-checking bench for flt_flt: real-arithmetic reference model, directed and random operand pairs.
`timescale 1ns/1ps
module tb_flt_flt;
  logic clk = 1'b0;
  logic reset;
  logic req;
  logic done;

  always #5 clk = ~clk;

  flt_flt #(.MEM_DEPTH(256), .OP_BASE(128)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .done  (done)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_res  = '0;
  bit          exp_valid = 1'b0;

  function automatic real pow2(input int k);
    real p = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) p = p * 2.0;
    else        for (int i = 0; i < -k; i++) p = p / 2.0;
    return p;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  e = int'(h[14:10]);
    real v;
    if (e == 0) return 0.0;
    v = (1.0 + real'(int'(h[9:0])) / 1024.0) * pow2(e - 15);
    return h[15] ? -v : v;
  endfunction

  // Exact sum, then truncation (or nearest-even) to the 1/5/10 grid with flush and saturation.
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    real  x = h2r(a) + h2r(b);
    real  ax, m;
    logic s;
    int   e, mi;
    if (x == 0.0) return 16'h0000;
    s  = (x < 0.0);
    ax = s ? -x : x;
    e  = 15;
    while (ax >= pow2(e - 14)) e++;
    while (ax <  pow2(e - 15)) e--;
    m  = (ax / pow2(e - 15) - 1.0) * 1024.0;
    mi = $rtoi(m);
`ifdef FLT_ROUND_NEAREST_EN
    begin
      real frac = m - real'(mi);
      if (frac > 0.5 || (frac == 0.5 && (mi % 2) == 1)) mi++;
      if (mi == 1024) begin mi = 0; e++; end
    end
`endif
    if (e < 1)  return {s, 15'd0};
    if (e > 31) return {s, 15'h7FFF};
    return {s, 5'(e), 10'(mi)};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req_v);
    end
  endtask

  function automatic logic [15:0] mem_res();
    return {dut.data_mem1.my_memory[132], dut.data_mem1.my_memory[133]};
  endfunction

  // Per-cycle compare: whenever done is up for a pending run, the stored sum must match the model.
  task automatic tick();
    @(negedge clk);
    if (exp_valid && done) check("result", {16'd0, mem_res()}, {16'd0, exp_res});
  endtask

  task automatic check_acc(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r);
    real x = h2r(a) + h2r(b);
    real ax = (x < 0.0) ? -x : x;
    real d;
    if (ax >= pow2(-14) && ax < pow2(17)) begin
      d = h2r(r) - x;
      if (d < 0.0) d = -d;
      n_checks++;
      if (d > 0.01 * ax) begin
        n_fail++;
        $display("FAIL accuracy %h+%h: got %h, required within 1%% of %f", a, b, r, x);
      end
    end
  endtask

  task automatic set_ops(input logic [15:0] a, input logic [15:0] b);
    dut.data_mem1.my_memory[128] <= a[15:8];
    dut.data_mem1.my_memory[129] <= a[7:0];
    dut.data_mem1.my_memory[130] <= b[15:8];
    dut.data_mem1.my_memory[131] <= b[7:0];
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b);
    int lat = 0;
    set_ops(a, b);
    exp_res   = model(a, b);
    exp_valid = 1'b1;
    req       = 1'b0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check("done_within_40", {31'd0, done}, 32'd1);
    if (done) begin
      check_acc(a, b, mem_res());
      for (int i = 0; i < 3; i++) begin
        tick();
        check("done_hold", {31'd0, done}, 32'd1);
      end
    end
    req = 1'b1;
    tick();
    check("done_release", {31'd0, done}, 32'd0);
    exp_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] a, b;
    logic [4:0]  eb;
    req   = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_done", {31'd0, done}, 32'd0);

    check("pin_1a04", {16'd0, model(16'h1A04, 16'h1A04)}, 32'h1E04);
    check("pin_4204", {16'd0, model(16'h4204, 16'h4204)}, 32'h4604);
    check("pin_4a10", {16'd0, model(16'h4A10, 16'h4204)}, 32'h4B91);
    check("pin_sub",  {16'd0, model(16'h4000, 16'hBC00)}, 32'h3C00);
    check("pin_canc", {16'd0, model(16'h3C00, 16'hBC00)}, 32'h0000);
    check("pin_sat",  {16'd0, model(16'h7FFF, 16'h7FFF)}, 32'h7FFF);
    check("pin_e0",   {16'd0, model(16'h0123, 16'h3C00)}, 32'h3C00);

    run(16'h1A04, 16'h1A04);
    check("tp1_hi", {24'd0, dut.data_mem1.my_memory[132]}, 32'h1E);
    check("tp1_lo", {24'd0, dut.data_mem1.my_memory[133]}, 32'h04);
    run(16'h4204, 16'h4204);
    run(16'h4A10, 16'h4204);
    run(16'h4000, 16'hBC00);
    run(16'h3C00, 16'hBC00);
    check("canc_lit", {16'd0, mem_res()}, 32'h0000);
    run(16'h7FFF, 16'h7FFF);
    check("sat_lit", {16'd0, mem_res()}, 32'h7FFF);
    run(16'h0123, 16'h3C00);
    run(16'h0000, 16'h8000);
    run(16'h0400, 16'h8401);
    run(16'h3C00, 16'h8001);

    // Reset while aligning a large exponent gap: no write, and no restart while req stays low.
    dut.data_mem1.my_memory[132] <= 8'hA5;
    dut.data_mem1.my_memory[133] <= 8'h5A;
    set_ops(16'h7800, 16'h0400);
    req = 1'b0;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_done", {31'd0, done}, 32'd0);
    repeat (45) tick();
    check("abort_no_restart", {31'd0, done}, 32'd0);
    check("abort_res", {16'd0, mem_res()}, 32'hA55A);
    req = 1'b1;
    tick();
    run(16'h7800, 16'h0400);

    for (int i = 0; i < 25; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        eb = a[14:10] + 5'($urandom_range(0, 3));
        b[14:10] = eb;
      end
      run(a, b);
    end

`ifdef FLT_ROUND_NEAREST_EN
    run(16'h3C00, 16'h1401);
    run(16'h3C00, 16'h1600);
    run(16'h3C00, 16'h1200);
    run(16'h7BFF, 16'h5000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
